// File: rtl/mem_req_pkg.sv
// Shared types and default widths for the memory request sequencer.
package mem_req_pkg;

  localparam int unsigned MemAddrW = 4;
  localparam int unsigned MemDataW = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StRdWait = 2'd2,
    StResp   = 2'd3
  } state_e;

  typedef struct packed {
    logic                wr;
    logic [MemAddrW-1:0] addr;
    logic [MemDataW-1:0] data;
  } req_t;

endpackage

// File: rtl/mem_req_stats.sv
// Saturating write/read issue counters for the memory request sequencer.
module mem_req_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_wr,
  input  logic        inc_rd,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (inc_wr && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 16'd1;
      if (inc_rd && (rd_cnt != 16'hFFFF)) rd_cnt <= rd_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request sequencer in front of a single-port memory; all outputs registered.
// Optional issue counters (wr_cnt/rd_cnt) when MEM_REQ_CTRL_STATS_EN is defined.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int unsigned ADDR_W = MemAddrW,
  parameter int unsigned DATA_W = MemDataW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_r_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_REQ_CTRL_STATS_EN
  ,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt
`endif
);

  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(RD_LAT - 1);

  state_e          state_q;
  logic            wr_q;
  logic [CntW-1:0] lat_cnt_q;

  // mem pins are loaded at acceptance so the request is on the bus during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_r_w    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wr_q       <= 1'b0;
      lat_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            wr_q      <= req_wr;
            mem_addr  <= req_addr;
            mem_r_w   <= req_wr;
            if (req_wr) mem_wdata <= req_wdata;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          mem_r_w   <= 1'b0;
          lat_cnt_q <= '0;
          if (wr_q) begin
            req_ready <= 1'b1;
            state_q   <= StIdle;
          end else begin
            state_q <= StRdWait;
          end
        end
        StRdWait: begin
          if (lat_cnt_q == LastCnt) begin
            resp_rdata <= mem_rdata;
            resp_valid <= 1'b1;
            state_q    <= StResp;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MEM_REQ_CTRL_STATS_EN
  logic inc_wr, inc_rd;
  assign inc_wr = (state_q == StIssue) && wr_q;
  assign inc_rd = (state_q == StIssue) && !wr_q;

  mem_req_stats u_stats (
    .clk    (clk),
    .rst    (rst),
    .inc_wr (inc_wr),
    .inc_rd (inc_rd),
    .wr_cnt (wr_cnt),
    .rd_cnt (rd_cnt)
  );
`endif

endmodule
